// File: rtl/tron_pkg.sv
// Shared encodings for the Tron input path: direction codes, PS/2 set-2 constants,
// the prefix FSM state type and the key-to-direction lookups.
package tron_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_D = 8'h23;

  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] dir;
  } key_t;

  function automatic key_t decode_p1(input logic [7:0] code);
    key_t k;
    k = '{hit: 1'b1, dir: DIR_UP};
    case (code)
      SC_W:    k.dir = DIR_UP;
      SC_A:    k.dir = DIR_LEFT;
      SC_S:    k.dir = DIR_DOWN;
      SC_D:    k.dir = DIR_RIGHT;
      default: k.hit = 1'b0;
    endcase
    return k;
  endfunction

  function automatic key_t decode_p2(input logic [7:0] code);
    key_t k;
    k = '{hit: 1'b1, dir: DIR_UP};
    case (code)
      SC_ARROW_UP:    k.dir = DIR_UP;
      SC_ARROW_LEFT:  k.dir = DIR_LEFT;
      SC_ARROW_DOWN:  k.dir = DIR_DOWN;
      SC_ARROW_RIGHT: k.dir = DIR_RIGHT;
      default:        k.hit = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/player_dir_slot.sv
// One player's pending/committed direction pair: latest key wins, reversals are
// refused, and tick commits the pending value with a one-cycle turn pulse on change.
module player_dir_slot
  import tron_pkg::*;
#(
  parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       turn
);

  logic [1:0] pend_dir;
  logic       pend_valid;
  logic       commit;
  logic [1:0] ref_dir;
  logic       key_ok;

  // A key arriving with a committing tick is judged against the value being committed.
  assign commit  = tick && pend_valid;
  assign ref_dir = commit ? pend_dir : dir;
  assign key_ok  = key_valid && (key_dir != (ref_dir ^ 2'b10));

  always_ff @(posedge clk) begin
    if (reset) begin
      dir        <= INIT_DIR;
      pend_dir   <= INIT_DIR;
      pend_valid <= 1'b0;
      turn       <= 1'b0;
    end else begin
      turn <= 1'b0;
      if (commit) begin
        dir        <= pend_dir;
        turn       <= (pend_dir != dir);
        pend_valid <= 1'b0;
      end
      if (key_ok) begin
        pend_dir   <= key_dir;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_direction_decoder.sv
// PS/2 set-2 prefix tracker that turns WASD and arrow make codes into per-player
// direction requests, committed on the game tick.
module scan_direction_decoder
  import tron_pkg::*;
#(
  parameter logic [1:0] P1_INIT_DIR = 2'b01,
  parameter logic [1:0] P2_INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_code_ready,
  input  logic       enable,
  input  logic       tick,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       p1_turn,
  output logic       p2_turn,
  output logic [1:0] fsm_state
);

  // scan_code is only meaningful while scan_code_ready is high; nothing here
  // stalls the keyboard receiver, so there is no ready back-pressure.
  prefix_state_t state;
  key_t          p1_key;
  key_t          p2_key;
  logic          p1_valid;
  logic          p2_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (scan_code_ready) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_EXT)      state <= ST_EXT;
          else if (scan_code == SC_BRK) state <= ST_BRK;
          else                          state <= ST_IDLE;
        end
        ST_EXT: begin
          if (scan_code == SC_BRK)      state <= ST_EXT_BRK;
          else if (scan_code == SC_EXT) state <= ST_EXT;
          else                          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fsm_state = state;
  assign p1_key    = decode_p1(scan_code);
  assign p2_key    = decode_p2(scan_code);

  // Unprefixed bytes can only be player 1, E0-prefixed bytes only player 2.
  assign p1_valid = scan_code_ready && enable && (state == ST_IDLE) && p1_key.hit;
  assign p2_valid = scan_code_ready && enable && (state == ST_EXT)  && p2_key.hit;

  player_dir_slot #(.INIT_DIR(P1_INIT_DIR)) u_p1 (
    .clk       (clk),
    .reset     (reset),
    .key_valid (p1_valid),
    .key_dir   (p1_key.dir),
    .tick      (tick),
    .dir       (p1_dir),
    .turn      (p1_turn)
  );

  player_dir_slot #(.INIT_DIR(P2_INIT_DIR)) u_p2 (
    .clk       (clk),
    .reset     (reset),
    .key_valid (p2_valid),
    .key_dir   (p2_key.dir),
    .tick      (tick),
    .dir       (p2_dir),
    .turn      (p2_turn)
  );

endmodule

// File: doc/scan_direction_decoder.md
SCAN_DIRECTION_DECODER -- requirements
Module: scan_direction_decoder

Interface
REQ-001 SHALL have parameter P1_INIT_DIR, default 2'b01 (right): player 1 direction after reset.
REQ-002 SHALL have parameter P2_INIT_DIR, default 2'b11 (left): player 2 direction after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port scan_code  input  8  PS/2 set-2 byte from the keyboard receiver.
REQ-006 SHALL have port scan_code_ready  input  1  one-cycle strobe; scan_code valid only in this cycle.
REQ-007 SHALL have port enable  input  1  high = gameplay active; low = bytes parsed but no pending updates.
REQ-008 SHALL have port tick  input  1  one-cycle game-step pulse; commits pending directions.
REQ-009 SHALL have port p1_dir  output  2  committed player 1 direction.
REQ-010 SHALL have port p2_dir  output  2  committed player 2 direction.
REQ-011 SHALL have port p1_turn  output  1  one-cycle pulse: p1_dir changed on this commit.
REQ-012 SHALL have port p2_turn  output  1  one-cycle pulse: p2_dir changed on this commit.

Function
REQ-013 SHALL encode directions as 00 up, 01 right, 10 down, 11 left.
REQ-014 SHALL map make codes: 1D/1C/1B/23 (W/A/S/D) to player 1 up/left/down/right.
REQ-015 SHALL map E0-prefixed make codes 75/6B/72/74 to player 2 up/left/down/right.
REQ-016 SHALL run a prefix FSM with states IDLE, EXT, BRK, EXT_BRK, advancing only when scan_code_ready=1.
REQ-017 SHALL transition IDLE: E0->EXT, F0->BRK, else decode non-extended byte and stay IDLE.
REQ-018 SHALL transition EXT: F0->EXT_BRK, E0->EXT, else decode extended byte and go IDLE.
REQ-019 SHALL discard the next byte in BRK and EXT_BRK (key release) and return to IDLE.
REQ-020 SHALL ignore unmapped codes, including unprefixed 75/6B/72/74 and E0-prefixed 1D/1C/1B/23.
REQ-021 SHALL keep one pending direction and a pending-valid flag per player; latest accepted key overwrites the pending value.
REQ-022 SHALL reject a key whose direction equals the reference direction XOR 2'b10 (180-degree reversal); the reference is the committed direction.
REQ-023 SHALL, when a key and tick coincide, commit the old pending value first, then evaluate the key against the newly committed direction and store it as pending.
REQ-024 SHALL, on tick with pending-valid set, load the committed register and clear pending-valid; pending-valid clear means no change.
REQ-025 SHALL update p*_dir in the cycle after tick (one-cycle latency).
REQ-026 SHALL assert p*_turn for exactly that cycle, only if the value changed; same-direction commits give no pulse.
REQ-027 SHALL not update pending state while enable=0, but the FSM still tracks prefixes; tick still commits already-pending values.
REQ-028 SHALL treat player 1 and player 2 fully independently; both may commit on the same tick.

Reset
REQ-029 SHALL, with reset high at a clk edge, set FSM=IDLE, p1_dir=P1_INIT_DIR, p2_dir=P2_INIT_DIR, pending-valid=0, p1_turn=p2_turn=0.
REQ-030 SHALL let reset override scan_code_ready and tick in the same cycle, abandoning any partial prefix sequence.

Structure
REQ-031 SHALL take direction encodings, scan-code constants (E0, F0, key codes) and the FSM state type from shared package tron_pkg.
REQ-032 SHALL implement pending/commit/reversal/turn logic once in sub-module player_dir_slot, instantiated twice.

Verification
REQ-033 SHALL verify: after reset, 1D then tick -> p1_dir=00 next cycle, p1_turn pulses once; p2_dir stays 11.
REQ-034 SHALL verify: p1_dir=01, send 1C (left) then tick -> rejected, p1_dir stays 01, no p1_turn.
REQ-035 SHALL verify: E0,75 then tick -> p2_dir=00; E0,F0,75 then tick -> no change, FSM back in IDLE.
REQ-036 SHALL verify: F0,1D release only, then tick -> p1_dir unchanged; unprefixed 75 -> no p2 effect.
REQ-037 SHALL verify: p1_dir=01 with pending 00, key 1B (down) coinciding with tick -> p1_dir=00 committed; down rejected against 00, nothing pending.
REQ-038 SHALL verify: send E0, assert reset, release, send 75 -> ignored (FSM restarted in IDLE); enable=0 with 23 then tick -> no change.
